// File: rtl/fp_accum_seq_pkg.sv
// Shared constants and types for the fp32 accumulate sequencer.
// Zero/denormal operand skipping is enabled with ACC_ZERO_SKIP_EN.
package fp_accum_seq_pkg;

  localparam int FP_W      = 32;
  localparam int CNT_W_DEF = 16;

  // Accumulator value at reset, after a len=0 run, and on fp_arith while disabled
  localparam logic [FP_W-1:0] ACCUM_INIT = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ACCUM = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic exp_is_zero(input logic [FP_W-1:0] x);
    return x[30:23] == 8'd0;
  endfunction

endpackage

// File: rtl/fp_arith.sv
// Combinational fp32 add/subtract, round-to-nearest-even, normal operands only.
// Output is ACCUM_INIT whenever en is low.
module fp_arith
  import fp_accum_seq_pkg::*;
(
  input  logic            en,
  input  logic            op_sel,
  input  logic [FP_W-1:0] data_1,
  input  logic [FP_W-1:0] data_2,
  output logic [FP_W-1:0] data_o
);

  logic               s1, s2, sl, ss, eff_sub;
  logic [7:0]         el, es, d;
  logic [26:0]        ml, ms, ms_sh, nrm;
  logic [27:0]        sum;
  logic [4:0]         lz;
  logic [24:0]        mr;
  logic signed [9:0]  e_n, e_r;
  logic [FP_W-1:0]    res;

  always_comb begin
    s1 = data_1[31];
    s2 = data_2[31] ^ op_sel;
    // Larger magnitude goes on the left so the difference never goes negative
    if (data_2[30:0] > data_1[30:0]) begin
      sl = s2; el = data_2[30:23]; ml = {1'b1, data_2[22:0], 3'b000};
      ss = s1; es = data_1[30:23]; ms = {1'b1, data_1[22:0], 3'b000};
    end else begin
      sl = s1; el = data_1[30:23]; ml = {1'b1, data_1[22:0], 3'b000};
      ss = s2; es = data_2[30:23]; ms = {1'b1, data_2[22:0], 3'b000};
    end
    eff_sub = sl ^ ss;
    d       = el - es;

    // Align with guard/round bits and a sticky bit folded into the LSB
    if (d >= 8'd27)
      ms_sh = {26'd0, |ms};
    else
      ms_sh = (ms >> d) | {26'd0, |(ms & ~(27'h7FF_FFFF << d))};

    sum = eff_sub ? ({1'b0, ml} - {1'b0, ms_sh}) : ({1'b0, ml} + {1'b0, ms_sh});

    lz = 5'd0;
    if (sum[27]) begin
      nrm = {sum[27:2], sum[1] | sum[0]};
      e_n = $signed({2'b00, el}) + 10'sd1;
    end else begin
      for (int i = 0; i < 27; i++)
        if (sum[i]) lz = 5'(26 - i);
      nrm = sum[26:0] << lz;
      e_n = $signed({2'b00, el}) - $signed({5'd0, lz});
    end

    mr  = {1'b0, nrm[26:3]} + 25'(nrm[2] & ((|nrm[1:0]) | nrm[3]));
    e_r = mr[24] ? e_n + 10'sd1 : e_n;

    if (sum == 28'd0)
      res = '0;
    else if (e_r <= 10'sd0)
      res = {sl, 31'd0};
    else if (e_r >= 10'sd255)
      res = {sl, 8'hFF, 23'd0};
    else
      res = {sl, e_r[7:0], mr[24] ? 23'd0 : mr[22:0]};

    data_o = en ? res : ACCUM_INIT;
  end

endmodule

// File: rtl/fp_accum_seq.sv
// Streams a run of fp32 operands through one fp_arith, folding them into a running result.
// Optional ACC_ZERO_SKIP_EN: zero/denormal beats are counted but leave acc untouched.
module fp_accum_seq
  import fp_accum_seq_pkg::*;
#(
  parameter int DATA_WIDTH = FP_W,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_W-1:0]      len,
  input  logic                  op_sel,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  busy
);

  state_t                state, state_d;
  logic [DATA_WIDTH-1:0] acc, acc_d, arith_o;
  logic [CNT_W-1:0]      cnt, cnt_d;
  logic                  op_q, op_d;
  logic                  beat, last, zero_beat;

  fp_arith u_arith (
    .en     (state == ACCUM),
    .op_sel (op_q),
    .data_1 (acc),
    .data_2 (in_data),
    .data_o (arith_o)
  );

  assign in_ready  = (state == LOAD) || (state == ACCUM);
  assign out_valid = (state == DONE);
  assign out_data  = acc;
  assign busy      = (state != IDLE);
  assign beat      = in_valid & in_ready;
  assign last      = (cnt == CNT_W'(1));

`ifdef ACC_ZERO_SKIP_EN
  assign zero_beat = exp_is_zero(in_data);
`else
  assign zero_beat = 1'b0;
`endif

  always_comb begin
    state_d = state;
    acc_d   = acc;
    cnt_d   = cnt;
    op_d    = op_q;
    case (state)
      IDLE: if (start) begin
        if (len != '0) begin
          state_d = LOAD;
          op_d    = op_sel;
          cnt_d   = len;
        end else begin
          state_d = DONE;
          acc_d   = ACCUM_INIT;
        end
      end
      // First operand is loaded raw: fp_arith cannot take a zero accumulator
      LOAD: if (beat) begin
        cnt_d   = cnt - CNT_W'(1);
        acc_d   = zero_beat ? ACCUM_INIT : in_data;
        state_d = last ? DONE : (zero_beat ? LOAD : ACCUM);
      end
      ACCUM: if (beat) begin
        cnt_d = cnt - CNT_W'(1);
        if (!zero_beat) acc_d = arith_o;
        if (last) state_d = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= ACCUM_INIT;
      cnt   <= '0;
      op_q  <= 1'b0;
    end else begin
      state <= state_d;
      acc   <= acc_d;
      cnt   <= cnt_d;
      op_q  <= op_d;
    end
  end

endmodule

// File: tb/tb_fp_accum_seq.sv
// Scoreboard bench for fp_accum_seq: integer-valued operands, expected result from plain integer math.
module tb_fp_accum_seq;
  import fp_accum_seq_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, op_sel = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] len = '0;
  logic [31:0] in_data = '0;
  logic        in_ready, out_valid, busy;
  logic [31:0] out_data;

  int          n_cmp = 0, n_bad = 0;
  logic [31:0] exp_q[$];
  bit          ready_mode = 1'b0, forced_ready = 1'b0;

  fp_accum_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .op_sel(op_sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Exact fp32 encoding of a positive integer below 2**24
  function automatic logic [31:0] i2f(input longint v);
    logic [31:0] u;
    int p;
    u = 32'(v);
    if (u == 32'd0) return 32'd0;
    p = 31;
    while (p > 0 && !u[p]) p--;
    return {1'b0, 8'(127 + p), 23'(u << (23 - p))};
  endfunction

  task automatic start_run(input logic [15:0] l, input logic op);
    start = 1'b1; len = l; op_sel = op;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] x);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = x;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin @(negedge clk); n++; end
    if (busy) check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    longint      acc;
    int unsigned l;
    bit          op;
    int unsigned v[$];

    fork
      forever begin
        @(negedge clk);
        #1 out_ready = ready_mode ? ($urandom_range(0, 2) != 0) : forced_ready;
        #1;
        if (rst_n && out_valid && out_ready) begin
          if (exp_q.size() == 0) check("unexpected_result", 32'd0, 32'd1);
          else check("result", out_data, exp_q.pop_front());
        end
      end
    join_none

    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, ACCUM_INIT);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Add run, back-to-back beats: 1+1+2
    forced_ready = 1'b1;
    exp_q.push_back(32'h4080_0000);
    start_run(16'd3, 1'b0);
    send_beat(32'h3F80_0000);
    send_beat(32'h3F80_0000);
    send_beat(32'h4000_0000);
    check("t1_out_valid_latency", {31'd0, out_valid}, 32'd1);
    check("t1_in_ready_done", {31'd0, in_ready}, 32'd0);

    // Subtract run: 3-1, busy coverage
    wait_idle();
    check("t2_busy_pre", {31'd0, busy}, 32'd0);
    exp_q.push_back(32'h4000_0000);
    start_run(16'd2, 1'b1);
    check("t2_busy_run", {31'd0, busy}, 32'd1);
    send_beat(32'h4040_0000);
    send_beat(32'h3F80_0000);
    check("t2_busy_done", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("t2_busy_after", {31'd0, busy}, 32'd0);

    // Sink backpressure with an ignored start pulse
    forced_ready = 1'b0;
    wait_idle();
    exp_q.push_back(32'h40A0_0000);
    start_run(16'd1, 1'b0);
    send_beat(32'h40A0_0000);
    for (int i = 0; i < 5; i++) begin
      check("t3_out_valid_hold", {31'd0, out_valid}, 32'd1);
      check("t3_out_data_hold", out_data, 32'h40A0_0000);
      check("t3_in_ready_low", {31'd0, in_ready}, 32'd0);
      start = (i == 2); len = 16'd5;
      @(negedge clk);
    end
    start = 1'b0;
    forced_ready = 1'b1;
    @(negedge clk);
    check("t3_idle_busy", {31'd0, busy}, 32'd0);
    check("t3_idle_out_valid", {31'd0, out_valid}, 32'd0);
    check("t3_idle_out_data", out_data, 32'h40A0_0000);
    @(negedge clk);
    check("t3_start_ignored", {31'd0, busy}, 32'd0);

    // len = 0
    forced_ready = 1'b0;
    exp_q.push_back(ACCUM_INIT);
    start_run(16'd0, 1'b0);
    check("t4_out_valid", {31'd0, out_valid}, 32'd1);
    check("t4_in_ready", {31'd0, in_ready}, 32'd0);
    check("t4_out_data", out_data, ACCUM_INIT);
    forced_ready = 1'b1;
    wait_idle();

    // Async reset mid-run
    forced_ready = 1'b0;
    start_run(16'd4, 1'b0);
    send_beat(32'h3F80_0000);
    send_beat(32'h4000_0000);
    rst_n = 1'b0;
    #1;
    check("t5_in_ready", {31'd0, in_ready}, 32'd0);
    check("t5_out_valid", {31'd0, out_valid}, 32'd0);
    check("t5_out_data", out_data, ACCUM_INIT);
    check("t5_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("t5_post_busy", {31'd0, busy}, 32'd0);
    check("t5_post_out_valid", {31'd0, out_valid}, 32'd0);

`ifdef ACC_ZERO_SKIP_EN
    forced_ready = 1'b1;
    exp_q.push_back(32'h4000_0000);
    start_run(16'd4, 1'b0);
    send_beat(32'h0000_0000);
    send_beat(32'h3F80_0000);
    send_beat(32'h0000_0000);
    send_beat(32'h3F80_0000);
    wait_idle();
`endif

    // Randomized runs with input gaps and random sink stalls
    ready_mode = 1'b1;
    for (int r = 0; r < 25; r++) begin
      l  = $urandom_range(1, 10);
      op = 1'($urandom_range(0, 1));
      v.delete();
      for (int i = 0; i < int'(l); i++)
        v.push_back((op && i == 0) ? $urandom_range(2000, 60000) : $urandom_range(1, op ? 100 : 1000));
      acc = v[0];
      for (int i = 1; i < int'(l); i++) acc = op ? acc - v[i] : acc + v[i];
      wait_idle();
      exp_q.push_back(i2f(acc));
      start_run(16'(l), op);
      for (int i = 0; i < int'(l); i++) begin
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        send_beat(i2f(v[i]));
      end
    end
    wait_idle();
    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
